alarm_bank: RTL and testbench
=============================

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter N_ALARM, default 4, number of alarm channels (legal range 1..8).
REQ-002 Parameter RING_SECS, default 60, ring duration in tick_1hz pulses before auto-stop.
REQ-003 Parameter SNOOZE_SECS, default 300, snooze duration in tick_1hz pulses.
REQ-004 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 sel  input  3  channel selected for editing and display.
REQ-007 cnt_inc  input  3  one-cycle increment pulses for the selected channel: bit0 seconds, bit1 minutes, bit2 hours.
REQ-008 cnt_dec  input  3  one-cycle decrement pulses, same bit mapping as cnt_inc.
REQ-009 en_toggle  input  1  one-cycle pulse that toggles the enable bit of the selected channel.
REQ-010 now_time  input  32  current time, packed {s0,s1,4'hA,m0,m1,4'hA,h0,h1}, where 0 is the BCD units digit and 1 is the BCD tens digit.
REQ-011 tick_1hz  input  1  one-cycle pulse, once per second.
REQ-012 stop  input  1  one-cycle pulse that silences all channels.
REQ-013 snooze  input  1  one-cycle pulse that snoozes all ringing channels.
REQ-014 Data  output  32  selected channel's alarm time, same packing as now_time.
REQ-015 en_vec  output  N_ALARM  per-channel enable bits.
REQ-016 ring_id  output  N_ALARM  per-channel ringing flags (state RING).
REQ-017 ring  output  1  OR of ring_id.

Function
REQ-018 Each channel SHALL hold BCD seconds 00-59, minutes 00-59 and hours 00-23.
REQ-019 Seconds and minutes fields SHALL wrap: inc 59->00, dec 00->59.
REQ-020 The hours field SHALL wrap: inc 23->00, inc x9->(x+1)0, dec 00->23, dec x0->(x-1)9.
REQ-021 Field edits SHALL NOT carry into or borrow from the adjacent field.
REQ-022 Within a field, inc SHALL take priority over dec when both are asserted.
REQ-023 Edits to different fields in the same cycle SHALL all apply.
REQ-024 Edits SHALL apply only to channel sel, and SHALL be visible on Data the next cycle.
REQ-025 If sel >= N_ALARM, edits and en_toggle SHALL be ignored and Data SHALL equal 32'hAAAA_AAAA.
REQ-026 Each channel SHALL implement the FSM states IDLE, RING and SNOOZE.
REQ-027 The SNOOZE state exists only under the configuration macro (REQ-039).
REQ-028 IDLE->RING SHALL occur on a tick_1hz cycle when the channel is enabled and its s/m/h digits equal now_time (separator nibbles ignored).
REQ-029 On that transition the channel's ring counter SHALL load to 0; ring_id SHALL assert on the following cycle.
REQ-030 In RING, each tick_1hz SHALL increment the counter; on reaching RING_SECS the channel SHALL return to IDLE.
REQ-031 A match while in RING or SNOOZE SHALL be ignored.
REQ-032 Transition priority, highest first: reset, stop, channel disable, snooze, timeout or tick.
REQ-033 stop SHALL send every RING or SNOOZE channel to IDLE.
REQ-034 A channel disabled by en_toggle SHALL go to IDLE in the same cycle.
REQ-035 Editing a ringing channel's time SHALL NOT change its state.
REQ-036 Multiple channels matching on the same tick SHALL all enter RING.
REQ-037 Counters SHALL be ceil(log2(max(RING_SECS,SNOOZE_SECS)+1)) bits wide and SHALL NOT overflow.

Reset
REQ-038 While Reset_n is low, all times SHALL be 00:00:00, en_vec SHALL be 0, all channels SHALL be IDLE, counters SHALL be 0, ring and ring_id SHALL be 0, and Data SHALL be 32'h00A0_0A00 for a valid sel; this applies even if reset asserts mid-ring.

Configuration
REQ-039 Macro ALARM_SNOOZE_EN: when defined, snooze SHALL move RING->SNOOZE with the counter cleared; after SNOOZE_SECS ticks the channel SHALL return to RING with the counter cleared.
REQ-040 Without ALARM_SNOOZE_EN, the snooze input SHALL be ignored, no SNOOZE state or snooze counter logic SHALL exist, and SNOOZE_SECS SHALL be unused.

Verification
REQ-041 Edit wrap: sel=1, hours=23, pulse cnt_inc[2] -> Data hours 00; then pulse cnt_dec[0] at seconds 00 -> seconds 59, minutes unchanged.
REQ-042 Match: ch0 enabled, set 07:30:05, now_time=07:30:05 with tick_1hz -> ring_id=4'b0001 next cycle; ch0 disabled with same time -> no ring.
REQ-043 Timeout: RING_SECS=3, after match apply 3 tick_1hz pulses -> ring deasserts the cycle after the 3rd tick.
REQ-044 Simultaneous: ch0 and ch2 at identical enabled times -> ring_id=4'b0101; stop pulse -> ring_id=0 next cycle.
REQ-045 Snooze (macro on, SNOOZE_SECS=2): ringing ch1 + snooze -> ring=0; after 2 ticks -> ring_id=4'b0010; macro off: snooze has no effect.
REQ-046 Reset mid-ring: assert Reset_n=0 asynchronously while ring=1 -> ring=0, en_vec=0 immediately.

Source files
------------

// File: rtl/alarm_bank.sv
// Bank of N_ALARM BCD alarm channels with per-channel ring/timeout FSMs.
// Optional snooze support is compiled in by defining ALARM_SNOOZE_EN.
module alarm_bank #(
    parameter int unsigned N_ALARM     = 4,
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [2:0]         sel,
    input  logic [2:0]         cnt_inc,
    input  logic [2:0]         cnt_dec,
    input  logic               en_toggle,
    input  logic [31:0]        now_time,
    input  logic               tick_1hz,
    input  logic               stop,
    input  logic               snooze,
    output logic [31:0]        Data,
    output logic [N_ALARM-1:0] en_vec,
    output logic [N_ALARM-1:0] ring_id,
    output logic               ring
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
    localparam int unsigned CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
`else
    typedef enum logic [0:0] {IDLE, RING} state_t;
    localparam int unsigned CNT_MAX = RING_SECS;
    localparam int unsigned unused_snooze_secs = SNOOZE_SECS;
`endif
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    // Separator nibbles never take part in matching.
    logic unused_bits;
`ifdef ALARM_SNOOZE_EN
    assign unused_bits = ^{now_time[23:20], now_time[11:8]};
`else
    assign unused_bits = ^{now_time[23:20], now_time[11:8], snooze};
`endif

    // BCD step for a 00-59 field {tens, units}; inc wins over dec.
    function automatic logic [7:0] ms_step(input logic [7:0] v, input logic inc, input logic dec);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (inc) begin
            if (u == 4'd9) begin
                u = 4'd0;
                t = (t == 4'd5) ? 4'd0 : t + 4'd1;
            end else begin
                u = u + 4'd1;
            end
        end else if (dec) begin
            if (u == 4'd0) begin
                u = 4'd9;
                t = (t == 4'd0) ? 4'd5 : t - 4'd1;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    // BCD step for the 00-23 hours field.
    function automatic logic [7:0] hr_step(input logic [7:0] v, input logic inc, input logic dec);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (inc) begin
            if (t == 4'd2 && u == 4'd3) begin
                t = 4'd0;
                u = 4'd0;
            end else if (u == 4'd9) begin
                t = t + 4'd1;
                u = 4'd0;
            end else begin
                u = u + 4'd1;
            end
        end else if (dec) begin
            if (t == 4'd0 && u == 4'd0) begin
                t = 4'd2;
                u = 4'd3;
            end else if (u == 4'd0) begin
                t = t - 4'd1;
                u = 4'd9;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    logic [31:0] packed_time [N_ALARM];

    for (genvar i = 0; i < N_ALARM; i++) begin : g_ch
        logic [7:0]    sec;
        logic [7:0]    min;
        logic [7:0]    hr;
        logic          en;
        logic [CW-1:0] cnt;
        state_t        st;
        logic          hit;
        logic          dis;
        logic          match;

        assign hit   = (sel == 3'(i));
        assign dis   = hit & en_toggle & en;
        assign packed_time[i] = {sec[3:0], sec[7:4], 4'hA, min[3:0], min[7:4], 4'hA, hr[3:0], hr[7:4]};
        assign match = ({packed_time[i][31:24], packed_time[i][19:12], packed_time[i][7:0]} ==
                        {now_time[31:24], now_time[19:12], now_time[7:0]});

        // Time edits and enable toggle for the selected channel.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                sec <= '0;
                min <= '0;
                hr  <= '0;
                en  <= 1'b0;
            end else if (hit) begin
                sec <= ms_step(sec, cnt_inc[0], cnt_dec[0]);
                min <= ms_step(min, cnt_inc[1], cnt_dec[1]);
                hr  <= hr_step(hr, cnt_inc[2], cnt_dec[2]);
                if (en_toggle) begin
                    en <= ~en;
                end
            end
        end

        // Ring FSM: stop > disable > snooze > timeout/tick.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                st  <= IDLE;
                cnt <= '0;
            end else if (stop || dis) begin
                st  <= IDLE;
                cnt <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (tick_1hz && en && match) begin
                            st  <= RING;
                            cnt <= '0;
                        end
                    end
                    RING: begin
`ifdef ALARM_SNOOZE_EN
                        if (snooze) begin
                            st  <= SNOOZE;
                            cnt <= '0;
                        end else
`endif
                        if (tick_1hz) begin
                            if (cnt == CW'(RING_SECS - 1)) begin
                                st  <= IDLE;
                                cnt <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    SNOOZE: begin
                        if (tick_1hz) begin
                            if (cnt == CW'(SNOOZE_SECS - 1)) begin
                                st  <= RING;
                                cnt <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
`endif
                    default: begin
                        st  <= IDLE;
                        cnt <= '0;
                    end
                endcase
            end
        end

        assign en_vec[i]  = en;
        assign ring_id[i] = (st == RING);
    end

    assign ring = |ring_id;

    // Display mux; out-of-range selections show the separator pattern.
    always_comb begin
        Data = 32'hAAAA_AAAA;
        for (int i = 0; i < N_ALARM; i++) begin
            if (sel == 3'(i)) begin
                Data = packed_time[i];
            end
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Randomized and directed bench for alarm_bank against a seconds-level reference model.
module tb_alarm_bank;

    localparam int N  = 4;
    localparam int RS = 3;
    localparam int SS = 2;

    logic          Clk;
    logic          Reset_n;
    logic [2:0]    sel;
    logic [2:0]    cnt_inc;
    logic [2:0]    cnt_dec;
    logic          en_toggle;
    logic [31:0]   now_time;
    logic          tick_1hz;
    logic          stop;
    logic          snooze;
    logic [31:0]   Data;
    logic [N-1:0]  en_vec;
    logic [N-1:0]  ring_id;
    logic          ring;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integer h/m/s, enable, state (0 idle, 1 ring, 2 snooze), counter.
    int mh [8];
    int mm [8];
    int ms [8];
    bit men [8];
    int mst [8];
    int mcnt [8];

    alarm_bank #(.N_ALARM(N), .RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .sel(sel), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec),
        .en_toggle(en_toggle), .now_time(now_time), .tick_1hz(tick_1hz), .stop(stop),
        .snooze(snooze), .Data(Data), .en_vec(en_vec), .ring_id(ring_id), .ring(ring)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] pack_t(input int h, input int m, input int s);
        return {4'(s % 10), 4'(s / 10), 4'hA, 4'(m % 10), 4'(m / 10), 4'hA, 4'(h % 10), 4'(h / 10)};
    endfunction

    function automatic logic [31:0] exp_data();
        if (int'(sel) < N) return pack_t(mh[sel], mm[sel], ms[sel]);
        return 32'hAAAA_AAAA;
    endfunction

    function automatic logic [N-1:0] exp_en();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = men[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_ring();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (mst[i] == 1);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mh[i] = 0; mm[i] = 0; ms[i] = 0; men[i] = 1'b0; mst[i] = 0; mcnt[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit hit;
            bit match;
            hit   = (int'(sel) == i);
            match = ((now_time & 32'hFF0F_F0FF) == (pack_t(mh[i], mm[i], ms[i]) & 32'hFF0F_F0FF));
            if (stop || (hit && en_toggle && men[i])) begin
                mst[i] = 0; mcnt[i] = 0;
            end else if (mst[i] == 0) begin
                if (tick_1hz && men[i] && match) begin mst[i] = 1; mcnt[i] = 0; end
            end else if (mst[i] == 1) begin
`ifdef ALARM_SNOOZE_EN
                if (snooze) begin mst[i] = 2; mcnt[i] = 0; end else
`endif
                if (tick_1hz) begin
                    mcnt[i]++;
                    if (mcnt[i] == RS) begin mst[i] = 0; mcnt[i] = 0; end
                end
            end else if (tick_1hz) begin
                mcnt[i]++;
                if (mcnt[i] == SS) begin mst[i] = 1; mcnt[i] = 0; end
            end
            if (hit) begin
                if (cnt_inc[0]) ms[i] = (ms[i] + 1) % 60; else if (cnt_dec[0]) ms[i] = (ms[i] + 59) % 60;
                if (cnt_inc[1]) mm[i] = (mm[i] + 1) % 60; else if (cnt_dec[1]) mm[i] = (mm[i] + 59) % 60;
                if (cnt_inc[2]) mh[i] = (mh[i] + 1) % 24; else if (cnt_dec[2]) mh[i] = (mh[i] + 23) % 24;
                if (en_toggle) men[i] = !men[i];
            end
        end
    endtask

    // One clock: inputs already driven, model follows the edge, pulses clear at negedge.
    task automatic step();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        cnt_inc = '0; cnt_dec = '0; en_toggle = 1'b0; tick_1hz = 1'b0; stop = 1'b0; snooze = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic set_time(input int ch, input int h, input int m, input int s);
        int dh, dm, ds;
        sel = 3'(ch);
        dh = (h - mh[ch] + 24) % 24;
        dm = (m - mm[ch] + 60) % 60;
        ds = (s - ms[ch] + 60) % 60;
        for (int k = 0; k < 60; k++) begin
            if (k >= dh && k >= dm && k >= ds) break;
            cnt_inc = {k < dh, k < dm, k < ds};
            step();
        end
    endtask

    task automatic toggle_en(input int ch);
        sel = 3'(ch);
        en_toggle = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; sel = 3'd0; cnt_inc = '0; cnt_dec = '0; en_toggle = 1'b0;
        now_time = '0; tick_1hz = 1'b0; stop = 1'b0; snooze = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        n_tests++; if (Data !== 32'h00A0_0A00) begin n_fail++; $display("FAIL reset_data got=%h exp=%h", Data, 32'h00A0_0A00); end
        n_tests++; if (en_vec !== '0) begin n_fail++; $display("FAIL reset_en got=%b exp=0", en_vec); end
        n_tests++; if (ring_id !== '0 || ring !== 1'b0) begin n_fail++; $display("FAIL reset_ring got=%b/%b exp=0/0", ring_id, ring); end
        sel = 3'd5;
        #1;
        n_tests++; if (Data !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL reset_badsel got=%h exp=aaaaaaaa", Data); end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_edit_wrap();
        do_reset();
        sel = 3'd1; cnt_dec = 3'b100; step();
        n_tests++; if (Data !== 32'h00A0_0A32) begin n_fail++; $display("FAIL hr_dec_wrap got=%h exp=00a00a32", Data); end
        cnt_inc = 3'b100; step();
        n_tests++; if (Data !== 32'h00A0_0A00) begin n_fail++; $display("FAIL hr_inc_wrap got=%h exp=00a00a00", Data); end
        cnt_dec = 3'b001; step();
        n_tests++; if (Data !== 32'h95A0_0A00) begin n_fail++; $display("FAIL sec_dec_wrap got=%h exp=95a00a00", Data); end
        sel = 3'd6; cnt_inc = 3'b111; en_toggle = 1'b1; step();
        sel = 3'd1;
        #1;
        n_tests++; if (Data !== 32'h95A0_0A00 || en_vec !== '0) begin n_fail++; $display("FAIL badsel_edit got=%h/%b exp=95a00a00/0", Data, en_vec); end
    endtask

    task automatic test_match();
        do_reset();
        set_time(0, 7, 30, 5);
        n_tests++; if (Data !== 32'h50A0_3A70) begin n_fail++; $display("FAIL set_time got=%h exp=50a03a70", Data); end
        toggle_en(0);
        now_time = 32'h50A0_3A70; tick_1hz = 1'b1; step();
        n_tests++; if (ring_id !== 4'b0001 || ring !== 1'b1) begin n_fail++; $display("FAIL match_ring got=%b exp=0001", ring_id); end
        stop = 1'b1; step();
        toggle_en(0);
        tick_1hz = 1'b1; step();
        n_tests++; if (ring_id !== 4'b0000 || en_vec !== 4'b0000) begin n_fail++; $display("FAIL disabled_match got=%b/%b exp=0000/0000", ring_id, en_vec); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_time(0, 7, 30, 5);
        toggle_en(0);
        now_time = 32'h50A0_3A70; tick_1hz = 1'b1; step();
        now_time = 32'h60A0_3A70;
        tick_1hz = 1'b1; step();
        step();
        tick_1hz = 1'b1; step();
        n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL timeout_early got=%b exp=1", ring); end
        tick_1hz = 1'b1; step();
        n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL timeout_end got=%b exp=0", ring); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_time(0, 1, 2, 3);
        set_time(2, 1, 2, 3);
        toggle_en(0);
        toggle_en(2);
        now_time = pack_t(1, 2, 3); tick_1hz = 1'b1; step();
        n_tests++; if (ring_id !== 4'b0101) begin n_fail++; $display("FAIL simul_ring got=%b exp=0101", ring_id); end
        sel = 3'd2; cnt_inc = 3'b001; step();
        n_tests++; if (ring_id !== 4'b0101) begin n_fail++; $display("FAIL edit_ringing got=%b exp=0101", ring_id); end
        stop = 1'b1; step();
        n_tests++; if (ring_id !== 4'b0000) begin n_fail++; $display("FAIL simul_stop got=%b exp=0000", ring_id); end
    endtask

    task automatic test_snooze();
        do_reset();
        set_time(1, 12, 0, 0);
        toggle_en(1);
        now_time = pack_t(12, 0, 0); tick_1hz = 1'b1; step();
        n_tests++; if (ring_id !== 4'b0010) begin n_fail++; $display("FAIL snooze_pre got=%b exp=0010", ring_id); end
        snooze = 1'b1; step();
`ifdef ALARM_SNOOZE_EN
        n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL snooze_quiet got=%b exp=0", ring); end
`else
        n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL snooze_ignored got=%b exp=1", ring); end
`endif
        tick_1hz = 1'b1; step();
        tick_1hz = 1'b1; step();
        n_tests++; if (ring_id !== 4'b0010) begin n_fail++; $display("FAIL snooze_after got=%b exp=0010", ring_id); end
    endtask

    task automatic test_reset_mid_ring();
        do_reset();
        set_time(3, 0, 0, 9);
        toggle_en(3);
        now_time = pack_t(0, 0, 9); tick_1hz = 1'b1; step();
        n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL midring_pre got=%b exp=1", ring); end
        #2 Reset_n = 1'b0;
        #1;
        n_tests++; if (ring !== 1'b0 || ring_id !== '0 || en_vec !== '0) begin n_fail++; $display("FAIL midring_reset got=%b/%b/%b exp=0/0/0", ring, ring_id, en_vec); end
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
            cnt_inc   = 3'($urandom & $urandom & $urandom);
            cnt_dec   = 3'($urandom & $urandom & $urandom);
            en_toggle = ($urandom_range(0, 9) == 0);
            tick_1hz  = ($urandom_range(0, 2) == 0);
            stop      = ($urandom_range(0, 59) == 0);
            snooze    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) begin
                int c;
                c = $urandom_range(0, N - 1);
                now_time = pack_t(mh[c], mm[c], ms[c]);
            end else begin
                now_time = $urandom;
            end
            step();
            n_tests++; if (Data !== exp_data()) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, Data, exp_data()); end
            n_tests++; if (en_vec !== exp_en()) begin n_fail++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", cyc, en_vec, exp_en()); end
            n_tests++; if (ring_id !== exp_ring()) begin n_fail++; $display("FAIL rnd_ring_id cyc=%0d got=%b exp=%b", cyc, ring_id, exp_ring()); end
            n_tests++; if (ring !== (|exp_ring())) begin n_fail++; $display("FAIL rnd_ring cyc=%0d got=%b exp=%b", cyc, ring, |exp_ring()); end
        end
    endtask

    initial begin
        test_reset();
        test_edit_wrap();
        test_match();
        test_timeout();
        test_simultaneous();
        test_snooze();
        test_reset_mid_ring();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
